// File: rtl/keyboard_ps2_rx_ctrl.sv
// -----------------------------------------------------------------------------
// keyboard_ps2_rx_ctrl
// PS/2 keyboard receive controller. Detects falling edges of the debounced
// PS/2 clock, assembles an 11-bit frame (start, 8 data LSB-first, odd parity,
// stop), validates it and queues good bytes in a circular FIFO.
//
// Optional build macro: KEYBOARD_PS2_RX_TIMEOUT_EN
//   defined   - a 16-bit inter-edge watchdog aborts a stalled frame after
//               TIMEOUT cycles with an oFRAME_ERR pulse.
//   undefined - no watchdog; a truncated frame is only recovered by reset.
// -----------------------------------------------------------------------------
module keyboard_ps2_rx_ctrl #(
  parameter int FIFO_DEPTH_N = 4,
  parameter int TIMEOUT      = 50000
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iPS2_CLK,
  input  logic                    iPS2_DATA,
  output logic                    oDATA_VALID,
  output logic [7:0]              oDATA,
  input  logic                    iDATA_REQ,
  output logic [FIFO_DEPTH_N:0]   oCOUNT,
  output logic                    oBUSY,
  output logic                    oPARITY_ERR,
  output logic                    oFRAME_ERR,
  output logic                    oOVERFLOW
);

  localparam int DEPTH = 1 << FIFO_DEPTH_N;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic                    r_prev_clk;
  logic [3:0]              r_bit_cnt;
  logic [8:0]              r_shift;     // {parity, data[7:0]} once complete
  logic                    r_parity_err;
  logic                    r_frame_err;
  logic                    r_overflow;

  logic [7:0]              r_mem [DEPTH];
  logic [FIFO_DEPTH_N-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_N-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_N:0]   r_count;

  logic                    w_fall;
  logic                    w_stop_edge;
  logic                    w_timeout;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_parity_err;
  logic                    w_frame_err;
  logic                    w_overflow;

  assign w_fall      = r_prev_clk & ~iPS2_CLK;
  assign w_stop_edge = (r_state == S_RECV) && w_fall && (r_bit_cnt == 4'd9);
  assign w_full      = (r_count == (FIFO_DEPTH_N+1)'(DEPTH));
  assign w_pop       = iDATA_REQ && oDATA_VALID;

`ifdef KEYBOARD_PS2_RX_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_timer;

  // Inter-edge watchdog: restarts on entry to RECV and on every clock fall.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_timer <= '0;
    end else if (iRESET_SYNC || w_fall || (r_state != S_RECV)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 16'd1;
    end
  end

  // A fall in the expiry cycle takes precedence over the timeout.
  assign w_timeout = (r_state == S_RECV) && !w_fall && (r_timer == TIMEOUT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!inRESET) begin
      r_state <= S_IDLE;
    end else if (iRESET_SYNC) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: enter RECV on a start bit, leave on stop bit or timeout.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_fall && !iPS2_DATA)    w_next_state = S_RECV;
      S_RECV: if (w_stop_edge || w_timeout) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: frame verdict in priority order framing, parity, overflow.
  always_comb begin
    w_push       = 1'b0;
    w_parity_err = 1'b0;
    w_frame_err  = 1'b0;
    w_overflow   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall && iPS2_DATA) w_frame_err = 1'b1;
      end
      S_RECV: begin
        if (w_stop_edge) begin
          if (!iPS2_DATA)            w_frame_err  = 1'b1;
          else if (!(^r_shift))      w_parity_err = 1'b1;
          else if (w_full && !w_pop) w_overflow   = 1'b1;
          else                       w_push       = 1'b1;
        end else if (w_timeout) begin
          w_frame_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Edge detector, bit sequencer and registered error pulses.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_prev_clk   <= 1'b1;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (iRESET_SYNC) begin
      r_prev_clk   <= 1'b1;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_prev_clk   <= iPS2_CLK;
      r_parity_err <= w_parity_err;
      r_frame_err  <= w_frame_err;
      r_overflow   <= w_overflow;
      if (r_state == S_IDLE) begin
        if (w_fall && !iPS2_DATA) r_bit_cnt <= '0;
      end else if (w_fall && !w_stop_edge) begin
        r_shift   <= {iPS2_DATA, r_shift[8:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge iCLOCK) begin
    // NOTE: the data array has no reset; validity is tracked by the pointers
    // and count, so clearing storage would only add reset fan-out.
    if (w_push) r_mem[r_wr_ptr] <= r_shift[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the depth.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (iRESET_SYNC) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_DEPTH_N+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_DEPTH_N+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign oDATA_VALID = (r_count != '0);
  assign oDATA       = oDATA_VALID ? r_mem[r_rd_ptr] : 8'h00;
  assign oCOUNT      = r_count;
  assign oBUSY       = (r_state == S_RECV);
  assign oPARITY_ERR = r_parity_err;
  assign oFRAME_ERR  = r_frame_err;
  assign oOVERFLOW   = r_overflow;

endmodule

// File: tb/tb_keyboard_ps2_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keyboard_ps2_rx_ctrl
// Self-checking bench: a directed vector table, hand-written corner sequences
// and randomized frames compared against a queue-based reference model.
// Honours KEYBOARD_PS2_RX_TIMEOUT_EN to pick the expected timeout behaviour.
// -----------------------------------------------------------------------------
module tb_keyboard_ps2_rx_ctrl;

  localparam int N       = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 50000;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         rsync = 1'b0;
  logic         ps2c  = 1'b1;
  logic         ps2d  = 1'b1;
  logic         req   = 1'b0;
  logic         valid;
  logic [7:0]   data;
  logic [N:0]   count;
  logic         busy;
  logic         perr;
  logic         ferr;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_ovf  = 0;

  logic [7:0] q[$];

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       pop;
    int         cnt;
    logic [7:0] head;
    int         perr;
    int         ferr;
    int         ovf;
  } vec_t;

  vec_t tbl[6];

  keyboard_ps2_rx_ctrl #(.FIFO_DEPTH_N(N), .TIMEOUT(TIMEOUT)) dut (
    .iCLOCK      (clk),
    .inRESET     (rst_n),
    .iRESET_SYNC (rsync),
    .iPS2_CLK    (ps2c),
    .iPS2_DATA   (ps2d),
    .oDATA_VALID (valid),
    .oDATA       (data),
    .iDATA_REQ   (req),
    .oCOUNT      (count),
    .oBUSY       (busy),
    .oPARITY_ERR (perr),
    .oFRAME_ERR  (ferr),
    .oOVERFLOW   (ovf)
  );

  always #5 clk = ~clk;

  // Count pulse cycles away from the active edge.
  always @(negedge clk) begin
    if (perr) n_perr <= n_perr + 1;
    if (ferr) n_ferr <= n_ferr + 1;
    if (ovf)  n_ovf  <= n_ovf + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic fall_bit(input logic b);
    ps2d = b;
    tick();
    ps2c = 1'b0;
    tick();
  endtask

  task automatic rise();
    tick();
    ps2c = 1'b1;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic pop);
    fall_bit(1'b0);
    rise();
    for (int i = 0; i < 8; i++) begin
      fall_bit(d[i]);
      rise();
    end
    fall_bit(par);
    rise();
    ps2d = stop;
    tick();
    ps2c = 1'b0;
    req  = pop;
    tick();
    req  = 1'b0;
    rise();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    req   = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    q.delete();
  endtask

  task automatic check_fifo(input string tag);
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_valid"}, 32'(valid), 32'(q.size() > 0));
    check({tag, "_data"},  32'(data),  (q.size() > 0) ? 32'(q[0]) : 32'h0);
  endtask

  // Reference frame: verdict derived from frame contents and model occupancy.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop,
                             input logic pop);
    int p0, f0, o0;
    int ep, ef, eo;
    logic do_pop;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
    ep = 0; ef = 0; eo = 0;
    do_pop = pop && (q.size() > 0);
    if (!stop)                                ef = 1;
    else if ((^{d, par}) == 1'b0)             ep = 1;
    else if (q.size() == DEPTH && !do_pop)    eo = 1;
    if (do_pop) void'(q.pop_front());
    if (ef == 0 && ep == 0 && eo == 0) q.push_back(d);
    send_frame(d, par, stop, pop);
    check("frame_busy", 32'(busy), 32'h0);
    check("frame_perr", 32'(n_perr - p0), 32'(ep));
    check("frame_ferr", 32'(n_ferr - f0), 32'(ef));
    check("frame_ovf",  32'(n_ovf - o0),  32'(eo));
    check_fifo("frame");
  endtask

  task automatic model_pop();
    req = 1'b1;
    tick();
    req = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check_fifo("pop");
  endtask

  initial begin
    logic [7:0] first_byte;
    logic [7:0] d;
    int p0, f0, o0;
    int waited;

    tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1, 8'h1C, 0, 0, 0};
    tbl[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1, 8'h1C, 1, 0, 0};
    tbl[2] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1, 8'h1C, 0, 1, 0};
    tbl[3] = '{8'hF0, 1'b1, 1'b1, 1'b0, 2, 8'h1C, 0, 0, 0};
    tbl[4] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1, 8'hF0, 1, 0, 0};
    tbl[5] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1, 8'h5A, 0, 0, 0};

    // Reset state.
    tick();
    tick();
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_data",  32'(data),  32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_pulses", 32'({perr, ferr, ovf}), 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'h0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
      send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, tbl[i].pop);
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_head", i),  32'(data),  32'(tbl[i].head));
      check($sformatf("tbl%0d_perr", i),  32'(n_perr - p0), 32'(tbl[i].perr));
      check($sformatf("tbl%0d_ferr", i),  32'(n_ferr - f0), 32'(tbl[i].ferr));
      check($sformatf("tbl%0d_ovf", i),   32'(n_ovf - o0),  32'(tbl[i].ovf));
      check($sformatf("tbl%0d_busy", i),  32'(busy), 32'h0);
    end

    // Two frames then pops, including a pop while empty.
    apply_reset();
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("pop_cnt2", 32'(count), 32'd2);
    check("pop_head0", 32'(data), 32'hF0);
    req = 1'b1; tick(); req = 1'b0;
    check("pop_cnt1", 32'(count), 32'd1);
    check("pop_head1", 32'(data), 32'h1C);
    req = 1'b1; tick(); req = 1'b0;
    check("pop_cnt0", 32'(count), 32'd0);
    check("pop_valid0", 32'(valid), 32'h0);
    check("pop_data0", 32'(data), 32'h0);
    req = 1'b1; tick(); req = 1'b0; tick();
    check("pop_empty_cnt", 32'(count), 32'd0);
    check("pop_empty_valid", 32'(valid), 32'h0);

    // Stray fall with data high in IDLE, then data toggles without clock.
    f0 = n_ferr;
    fall_bit(1'b1);
    rise();
    check("idle_hi_ferr", 32'(n_ferr - f0), 32'd1);
    check("idle_hi_busy", 32'(busy), 32'h0);
    f0 = n_ferr;
    for (int i = 0; i < 6; i++) begin
      ps2d = ~ps2d;
      tick();
    end
    check("data_glitch_busy", 32'(busy), 32'h0);
    check("data_glitch_ferr", 32'(n_ferr - f0), 32'd0);

    // Fill to full, overflow, then overflow-frame with simultaneous pop.
    apply_reset();
    first_byte = 8'($urandom);
    model_frame(first_byte, odd_par(first_byte), 1'b1, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      d = 8'($urandom);
      model_frame(d, odd_par(d), 1'b1, 1'b0);
    end
    check("full_count", 32'(count), 32'd16);
    d = 8'h3C;
    model_frame(d, odd_par(d), 1'b1, 1'b0);
    check("ovf_head_first", 32'(data), 32'(first_byte));
    model_frame(d, odd_par(d), 1'b1, 1'b1);
    check("full_pop_count", 32'(count), 32'd16);

    // Randomized frames against the reference model.
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        f0 = n_ferr;
        fall_bit(1'b1);
        rise();
        check("rnd_idle_ferr", 32'(n_ferr - f0), 32'd1);
      end
      model_frame(d,
                  ($urandom_range(0, 5) == 0) ? ~odd_par(d) : odd_par(d),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) model_pop();
    end

    // Truncated frame: start plus three data bits, then silence.
    apply_reset();
    f0 = n_ferr;
    fall_bit(1'b0); rise();
    fall_bit(1'b0); rise();
    fall_bit(1'b1); rise();
    fall_bit(1'b1); rise();
    check("trunc_busy", 32'(busy), 32'h1);
    waited = 0;
`ifdef KEYBOARD_PS2_RX_TIMEOUT_EN
    while (busy && waited < TIMEOUT + 100) begin
      tick();
      waited++;
    end
    check("timeout_busy", 32'(busy), 32'h0);
    check("timeout_ferr", 32'(n_ferr - f0), 32'd1);
    model_frame(8'h1C, 1'b0, 1'b1, 1'b0);
`else
    while (waited < TIMEOUT + 100) begin
      tick();
      waited++;
    end
    check("no_timeout_busy", 32'(busy), 32'h1);
    check("no_timeout_ferr", 32'(n_ferr - f0), 32'd0);
    rsync = 1'b1; tick(); rsync = 1'b0;
    q.delete();
    check("no_timeout_rsync_busy", 32'(busy), 32'h0);
`endif

    // Synchronous reset mid-frame with three bytes queued.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      d = 8'(8'h40 + i);
      model_frame(d, odd_par(d), 1'b1, 1'b0);
    end
    fall_bit(1'b0); rise();
    for (int i = 0; i < 6; i++) begin
      fall_bit(1'(i & 1));
      rise();
    end
    check("srst_pre_count", 32'(count), 32'd3);
    check("srst_pre_busy", 32'(busy), 32'h1);
    rsync = 1'b1; tick(); rsync = 1'b0;
    q.delete();
    check("srst_busy", 32'(busy), 32'h0);
    check_fifo("srst");
    model_frame(8'h1C, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-frame, checked before any clock edge.
    fall_bit(1'b0); rise();
    fall_bit(1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(busy),  32'h0);
    check("arst_count", 32'(count), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_data",  32'(data),  32'h0);
    check("arst_pulses", 32'({perr, ferr, ovf}), 32'h0);
    ps2c = 1'b1;
    ps2d = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    q.delete();
    model_frame(8'hF0, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keyboard_ps2_rx_ctrl.md
Name: keyboard_ps2_rx_ctrl

Overview:
Receive controller for the PS/2 keyboard port. It runs behind the keyboard chattering cancellers, which debounce PS/2 clock and data at a 25us sample period on the 50MHz clock. It detects falling edges of the debounced keyboard clock, sequences the 11-bit frame (start, 8 data LSB-first, odd parity, stop), and validates it. Good bytes are queued in a small FIFO that the keyboard register interface pops.

Parameters:
FIFO_DEPTH_N, 4, log2 of the FIFO depth (default 16 entries).
TIMEOUT, 50000, inter-edge timeout in iCLOCK cycles (1ms at 50MHz); only used with the optional feature.

Ports:
iCLOCK  input  1  system clock, 50MHz
inRESET  input  1  asynchronous active-low reset
iRESET_SYNC  input  1  synchronous reset, active high; same effect as inRESET
iPS2_CLK  input  1  debounced PS/2 clock
iPS2_DATA  input  1  debounced PS/2 data
oDATA_VALID  output  1  FIFO not empty
oDATA  output  8  FIFO head byte; 0x00 when empty
iDATA_REQ  input  1  pop request; honoured only when oDATA_VALID=1
oCOUNT  output  FIFO_DEPTH_N+1  FIFO occupancy
oBUSY  output  1  high while a frame is in progress
oPARITY_ERR  output  1  one-cycle pulse: frame dropped, bad parity
oFRAME_ERR  output  1  one-cycle pulse: bad start bit, bad stop bit, or timeout
oOVERFLOW  output  1  one-cycle pulse: good frame dropped because the FIFO was full

Behaviour:
- Reset (inRESET low, or iRESET_SYNC high at a clock edge):
  - state=IDLE, edge register=1, bit count=0, shift register=0.
  - FIFO emptied.
  - All outputs 0.
- Falling-edge detect: fall = prev_clk & ~iPS2_CLK, where prev_clk is iPS2_CLK registered every cycle. All state actions occur at the clock edge where fall=1.
- IDLE:
  - fall with iPS2_DATA=0: go to RECV, bit count=0.
  - fall with iPS2_DATA=1: pulse oFRAME_ERR, stay in IDLE.
- RECV, bits 0..8: on each fall, shift iPS2_DATA in LSB-first and increment the bit count. Bits 0-7 are data; bit 8 is parity.
- RECV, bit 9 (stop): on the fall, evaluate in this priority order:
  1. stop bit=0: pulse oFRAME_ERR, drop the frame.
  2. XOR of data and parity is 0: pulse oPARITY_ERR, drop the frame.
  3. FIFO full and no simultaneous pop: pulse oOVERFLOW, drop the frame.
  4. Otherwise push the byte.
  In every case return to IDLE on the same edge.
- oBUSY = (state==RECV).
- Push latency: the byte appears on oDATA/oDATA_VALID the cycle after the stop-bit fall edge.
- FIFO:
  - Circular buffer with FIFO_DEPTH_N-bit pointers that wrap modulo the depth; oCOUNT ranges 0..2^FIFO_DEPTH_N.
  - oDATA is the registered head.
  - Pop when iDATA_REQ && oDATA_VALID; iDATA_REQ while empty is ignored.
  - Simultaneous push and pop: both performed, count unchanged, including when full.
- Error pulses are mutually exclusive within a cycle. A dropped frame never alters the FIFO.
- Level changes on iPS2_DATA without a clock fall are ignored.

Optional Feature:
KEYBOARD_PS2_RX_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to RECV and on every fall, and increments each cycle while in RECV.
  - When it reaches TIMEOUT-1 with no fall: pulse oFRAME_ERR, return to IDLE, discard the partial frame.
  - If a fall occurs in that same cycle, the fall wins.
- Undefined: no counter exists; RECV waits indefinitely. Only a reset recovers a truncated frame.

Test Plan:
- Frame 0x1C, parity 0, stop 1 -> oDATA_VALID=1 one cycle after the stop fall; oDATA=0x1C; oCOUNT=1; no error pulses; oBUSY low after the stop fall.
- Frames 0xF0 (parity 1) then 0x1C, then iDATA_REQ for 2 cycles -> oDATA reads 0xF0 then 0x1C; oCOUNT goes 2,1,0; oDATA_VALID=0; a third iDATA_REQ has no effect.
- Frame 0x1C with parity 1 -> single oPARITY_ERR pulse, oCOUNT stays 0. Frame with stop=0 -> single oFRAME_ERR pulse. Fall with data=1 in IDLE -> oFRAME_ERR, state stays IDLE.
- 16 good frames -> oCOUNT=16. 17th frame -> oOVERFLOW pulse, oCOUNT=16, head still the first byte. Repeat the 17th frame with iDATA_REQ asserted on the stop-fall cycle -> no overflow, oCOUNT=16.
- (Feature on) 4 bits of a frame, then no edges for 50000 cycles -> oFRAME_ERR, oBUSY=0. A following clean 0x1C frame is received correctly. (Feature off) same stimulus -> oBUSY stays 1.
- iRESET_SYNC pulse mid-frame after bit 5 with oCOUNT=3 -> next cycle oBUSY=0, oCOUNT=0, oDATA_VALID=0. Next full frame 0x1C is received correctly. Asynchronous inRESET assertion -> all outputs 0 immediately, without waiting for a clock edge.
